sync_fifo_param: RTL

//  Single-clock parametrised FIFO; successor to the dual-clock MAC buffer FIFO for same-domain paths
//  (TX/RX staging between LMAC pipeline stages). Adds power-of-two depth generalisation, show-ahead mode,

---
 rtl/sync_fifo_param.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO: registered or show-ahead read, programmable almost flags, flush, ovf/udf.
// Optional build macro SYNC_FIFO_ERR_STICKY_EN makes ovf/udf sticky until err_clr or reset.
module sync_fifo_param #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 16,
    parameter int PTR       = 4,
    parameter int SHOWAHEAD = 0,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wren,
    input  logic [WIDTH-1:0] datain,
    output logic             wrfull,
    output logic             wralmfull,
    input  logic             rden,
    output logic [WIDTH-1:0] dataout,
    output logic             rdempty,
    output logic             rdalmempty,
    output logic [PTR:0]     usedw,
    output logic             ovf,
    output logic             udf,
    input  logic             err_clr
);

    localparam logic [PTR-1:0] PTR_ONE  = {{(PTR-1){1'b0}}, 1'b1};
    localparam logic [PTR:0]   CNT_ONE  = {{PTR{1'b0}}, 1'b1};
    localparam logic [PTR:0]   CNT_ZERO = '0;
    localparam logic [PTR:0]   DEPTH_C  = DEPTH[PTR:0];
    localparam logic [PTR:0]   AFULL_C  = AFULL_TH[PTR:0];
    localparam logic [PTR:0]   AEMPTY_C = AEMPTY_TH[PTR:0];

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR-1:0] wr_ptr_p0;
    logic [PTR-1:0] rd_ptr_p0;
    logic [PTR:0]   cnt_p0;
    logic           full_p0;
    logic           almfull_p0;
    logic           empty_p0;
    logic           almempty_p0;
    logic           ovf_p0;
    logic           udf_p0;

    logic           wr_acc;
    logic           rd_acc;
    logic           ovf_evt;
    logic           udf_evt;
    logic           ovf_nxt;
    logic           udf_nxt;
    logic [PTR:0]   cnt_nxt;

    // Depth is a power of two, so natural overflow of the PTR-bit sum is the modulo wrap.
    function automatic logic [PTR-1:0] ptr_inc(input logic [PTR-1:0] p);
        return p + PTR_ONE;
    endfunction

    // Occupancy step, clamped to 0..DEPTH.
    function automatic logic [PTR:0] cnt_step(input logic [PTR:0] c, input logic inc,
                                              input logic dec);
        logic [PTR:0] r;
        r = c;
        if (inc && !dec && (c != DEPTH_C)) begin
            r = c + CNT_ONE;
        end else if (dec && !inc && (c != CNT_ZERO)) begin
            r = c - CNT_ONE;
        end
        return r;
    endfunction

    always_comb begin
        wr_acc  = wren & ~full_p0 & ~flush;
        rd_acc  = rden & ~empty_p0 & ~flush;
        ovf_evt = wren & full_p0 & ~flush;
        udf_evt = rden & empty_p0 & ~flush;
        cnt_nxt = flush ? CNT_ZERO : cnt_step(cnt_p0, wr_acc, rd_acc);
`ifdef SYNC_FIFO_ERR_STICKY_EN
        // Set wins over clear when both happen in the same cycle.
        ovf_nxt = ovf_evt | (ovf_p0 & ~err_clr);
        udf_nxt = udf_evt | (udf_p0 & ~err_clr);
`else
        ovf_nxt = ovf_evt;
        udf_nxt = udf_evt;
`endif
    end

`ifndef SYNC_FIFO_ERR_STICKY_EN
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

    // Stage p0: pointers, occupancy and flags, all derived from the next-state count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_p0   <= '0;
            rd_ptr_p0   <= '0;
            cnt_p0      <= '0;
            full_p0     <= 1'b0;
            almfull_p0  <= 1'b0;
            empty_p0    <= 1'b1;
            almempty_p0 <= 1'b1;
            ovf_p0      <= 1'b0;
            udf_p0      <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_p0 <= '0;
                rd_ptr_p0 <= '0;
            end else begin
                if (wr_acc) wr_ptr_p0 <= ptr_inc(wr_ptr_p0);
                if (rd_acc) rd_ptr_p0 <= ptr_inc(rd_ptr_p0);
            end
            cnt_p0      <= cnt_nxt;
            full_p0     <= (cnt_nxt == DEPTH_C);
            almfull_p0  <= (cnt_nxt >= AFULL_C);
            empty_p0    <= (cnt_nxt == CNT_ZERO);
            almempty_p0 <= (cnt_nxt <= AEMPTY_C);
            ovf_p0      <= ovf_nxt;
            udf_p0      <= udf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_p0] <= datain;
    end

    // Stage p1: read data path.
    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            // Head word is visible as soon as the registered empty flag drops; forced to 0 when empty.
            assign dataout = empty_p0 ? '0 : mem[rd_ptr_p0];
        end else begin : g_registered
            logic [WIDTH-1:0] rd_data_p1;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_data_p1 <= '0;
                end else if (rd_acc) begin
                    rd_data_p1 <= mem[rd_ptr_p0];
                end
            end
            assign dataout = rd_data_p1;
        end
    endgenerate

    assign wrfull     = full_p0;
    assign wralmfull  = almfull_p0;
    assign rdempty    = empty_p0;
    assign rdalmempty = almempty_p0;
    assign usedw      = cnt_p0;
    assign ovf        = ovf_p0;
    assign udf        = udf_p0;

endmodule
